butterfly_scheduler: RTL
========================

# butterfly_scheduler

Sequencing controller for an iterative radix-2 DIT FFT built around one shared butterfly unit. On `start` it walks every stage and butterfly of an N-point transform. For each butterfly it issues operand indices and a twiddle index to the butterfly over a val/rdy handshake, then tracks in-flight operations in a tag FIFO. Returned results are written back to the correct buffer locations; the data buffer and twiddle ROM are external and addressed by this block.

## Interface
Parameters:
- `N`, 8: transform size; power of two, ≥4. `LOG_N` = log2(N).
- `MAX_INFLIGHT`, 4: max butterflies issued but not yet returned; power of two, ≥1.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin transform; sampled only in IDLE
- `busy`  out  1  high from the cycle after an accepted `start` until DONE
- `done`  out  1  one-cycle pulse when the last result is written back
- `bf_req_val`  out  1  butterfly issue valid
- `bf_req_rdy`  in  1  butterfly ready to accept
- `bf_a_idx`  out  LOG_N  buffer index of operand a
- `bf_b_idx`  out  LOG_N  buffer index of operand b
- `bf_tw_idx`  out  LOG_N-1  twiddle index k of W_N^k
- `bf_resp_val`  in  1  butterfly result valid; results return in issue order
- `bf_resp_rdy`  out  1  result accepted
- `wb_en`  out  1  write results to the buffer this cycle
- `wb_a_idx`  out  LOG_N  destination of c
- `wb_b_idx`  out  LOG_N  destination of d

## Operation
- States: IDLE, ISSUE, DRAIN, DONE. Registers: stage `s` (0..LOG_N-1), butterfly counter `k` (0..N/2-1), in-flight count, tag FIFO.
- IDLE: on `start`=1 → ISSUE with s=0, k=0.
- Index generation (pure function of s, k):
  - half = 2^s; j = k & (half-1); grp = k >> s.
  - a = grp·2·half + j; b = a + half.
  - tw = j << (LOG_N-1-s).
  - Index outputs are 0 whenever `bf_req_val`=0.
- ISSUE:
  - `bf_req_val` = (count < MAX_INFLIGHT).
  - On fire (val&rdy): push {a,b} to the tag FIFO; k++.
  - On the fire with k = N/2-1 → DRAIN.
- Responses (any state):
  - `bf_resp_rdy` = FIFO non-empty.
  - On resp fire: `wb_en`=1 combinationally in the same cycle, with `wb_a_idx`/`wb_b_idx` = FIFO head; pop.
  - `wb_*` indices are 0 when `wb_en`=0.
  - `bf_resp_val` with an empty FIFO is not accepted and is ignored.
- Count: +1 on issue fire, −1 on response fire; both in the same cycle → unchanged. Push and pop in the same cycle are legal, including at full (the pop frees the slot).
- DRAIN: when the registered count == 0:
  - s < LOG_N-1 → ISSUE with s++, k=0.
  - s = LOG_N-1 → DONE.
  - No next-stage issue may occur before all current-stage writebacks complete (RAW hazard).
- DONE: `done`=1 for one cycle → IDLE; `busy`=0 in DONE.
- `start` outside IDLE is ignored.
- Reset (any time): state IDLE, s=k=count=0, FIFO emptied. All outputs 0: `busy`, `done`, `bf_req_val`, `bf_resp_rdy`, `wb_en`, and all index outputs.

## Timing
- `start` sampled at edge t → `busy`=1 and `bf_req_val`=1 in cycle t+1.
- Peak throughput: one issue per cycle while `bf_req_rdy`=1 and count < MAX_INFLIGHT.
- Writeback has zero latency relative to the response handshake.
- Stage boundary: last response accepted at cycle t → count=0 at t+1 (DRAIN) → next-stage ISSUE at t+2.
- Last response at cycle t → DONE (`done`=1) at t+2 → IDLE at t+3.
- The FIFO-full decision uses the registered count only; same-cycle pops do not enable an issue.

## Structure
- Package `butterfly_sched_pkg`:
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - `clog2`-based width constants;
  - index-generation function `bf_indices(s, k)` returning a, b, tw.
- Sub-module `sched_tag_fifo`: synchronous FIFO, width 2·LOG_N, depth MAX_INFLIGHT, with push/pop/full/empty and asynchronous active-low reset.

## Test plan
- N=8, `bf_req_rdy`=1, response 1 cycle after issue → issue/writeback sequence:
  - s0: (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0;
  - s1: (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2;
  - s2: (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3;
  - 12 `wb_en` pulses, then one `done` pulse.
- MAX_INFLIGHT=2, responses withheld → exactly 2 issues, then `bf_req_val`=0. Releasing one response → exactly one more issue.
- Stage drain: delay stage-0's last response 10 cycles → no stage-1 issue until 2 cycles after it is accepted.
- `bf_req_rdy` toggled pseudo-randomly → identical index sequence, each index held stable while val=1 and rdy=0.
- `start` asserted while busy, and `bf_resp_val` asserted in IDLE → both ignored; no writeback, no restart.
- `reset` driven low mid-stage-1 with 3 in flight → all outputs 0 immediately. A new `start` then reproduces the full s0 sequence from (0,1).

Source files
------------

// File: rtl/butterfly_sched_pkg.sv
// butterfly_sched_pkg: shared state encoding, default widths and butterfly index generation
package butterfly_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam int DEF_N = 8;
  localparam int DEF_LOG_N = $clog2(DEF_N);
  localparam int DEF_MAX_INFLIGHT = 4;
  localparam int DEF_CNT_W = $clog2(DEF_MAX_INFLIGHT + 1);
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] tw;
  } bf_idx_t;
  // Radix-2 DIT: butterfly k of stage s pairs a and a+2^s within group k>>s
  function automatic bf_idx_t bf_indices(input int log_n, input int s, input int k);
    bf_idx_t r;
    int half;
    int j;
    half = 1 << s;
    j = k & (half - 1);
    r.a = (k >> s) * 2 * half + j;
    r.b = r.a + half;
    r.tw = j << (log_n - 1 - s);
    return r;
  endfunction
endpackage

// File: rtl/sched_tag_fifo.sv
// sched_tag_fifo: in-order tag FIFO; a pop frees its slot for a same-cycle push even when full
module sched_tag_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign dout_o = mem_q[rp_q];
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= do_push ? nxt(wp_q) : wp_q;
      rp_q <= do_pop ? nxt(rp_q) : rp_q;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end
endmodule

// File: rtl/butterfly_scheduler.sv
// butterfly_scheduler: walks all stages/butterflies of an N-point radix-2 DIT FFT,
// issuing operand/twiddle indices and writing results back in issue order.
module butterfly_scheduler
  import butterfly_sched_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    bf_req_val,
  input  logic                    bf_req_rdy,
  output logic [$clog2(N)-1:0]    bf_a_idx,
  output logic [$clog2(N)-1:0]    bf_b_idx,
  output logic [$clog2(N)-2:0]    bf_tw_idx,
  input  logic                    bf_resp_val,
  output logic                    bf_resp_rdy,
  output logic                    wb_en,
  output logic [$clog2(N)-1:0]    wb_a_idx,
  output logic [$clog2(N)-1:0]    wb_b_idx
);
  localparam int LOG_N = $clog2(N);
  localparam int KW = LOG_N - 1;
  localparam int SW = $clog2(LOG_N);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  state_t state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tag_full, tag_empty;
  logic [2*LOG_N-1:0] tag_head;
  logic iss_fire, resp_fire;
  bf_idx_t idx;
  logic unused_ok;
  assign idx = bf_indices(LOG_N, int'(s_q), int'(k_q));
  assign unused_ok = ^{idx, tag_full};
  // Issue gating uses only the registered count: a same-cycle pop never opens a slot
  assign bf_req_val = state_q == ISSUE && cnt_q < CW'(MAX_INFLIGHT);
  assign iss_fire = bf_req_val & bf_req_rdy;
  assign bf_a_idx = bf_req_val ? LOG_N'(idx.a) : '0;
  assign bf_b_idx = bf_req_val ? LOG_N'(idx.b) : '0;
  assign bf_tw_idx = bf_req_val ? KW'(idx.tw) : '0;
  assign bf_resp_rdy = ~tag_empty;
  assign resp_fire = bf_resp_val & ~tag_empty;
  assign wb_en = resp_fire;
  assign wb_a_idx = resp_fire ? tag_head[2*LOG_N-1:LOG_N] : '0;
  assign wb_b_idx = resp_fire ? tag_head[LOG_N-1:0] : '0;
  assign busy = state_q == ISSUE || state_q == DRAIN;
  assign done = state_q == DONE;
  assign cnt_d = cnt_q + CW'(iss_fire) - CW'(resp_fire);
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    k_d = k_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = ISSUE;
        s_d = '0;
        k_d = '0;
      end
      ISSUE: if (iss_fire) begin
        k_d = k_q + 1'b1;
        state_d = k_q == '1 ? DRAIN : ISSUE;
      end
      DRAIN: if (cnt_q == '0) begin
        state_d = s_q == SW'(LOG_N - 1) ? DONE : ISSUE;
        s_d = s_q == SW'(LOG_N - 1) ? s_q : s_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q <= '0;
      k_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      k_q <= k_d;
      cnt_q <= cnt_d;
    end
  end
  sched_tag_fifo #(.WIDTH(2 * LOG_N), .DEPTH(MAX_INFLIGHT)) u_tags (
    .clk(clk),
    .reset(reset),
    .push_i(iss_fire),
    .pop_i(resp_fire),
    .din_i({bf_a_idx, bf_b_idx}),
    .dout_o(tag_head),
    .full_o(tag_full),
    .empty_o(tag_empty)
  );
endmodule
